// File: rtl/nn_pkg.sv
// Shared definitions for the neuron chain: default widths and bus helpers.
package nn_pkg;

  localparam int unsigned RESULT_WIDTH_DEFAULT = 16;

  // The valid flag sits directly above the result magnitude on the chain bus.
  localparam int unsigned RESULT_VALID_BIT = RESULT_WIDTH_DEFAULT;

  function automatic int unsigned result_valid_bit(input int unsigned result_width);
    return result_width;
  endfunction

  // Bits needed to hold a position 0..n-1; never narrower than one bit.
  function automatic int unsigned index_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Synchronous FIFO with occupancy count; full/empty come from the count so
// equal pointers are never ambiguous.
module result_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  // Pop only real entries; a push into a full FIFO is legal when a pop frees a slot.
  always_comb begin
    full    = (count_q == CNT_W'(DEPTH));
    empty   = (count_q == '0);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    count   = count_q;
    rd_data = empty ? '0 : mem[rd_ptr];
  end

  // Pointer and occupancy tracking; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is unreset; rd_data is masked to zero while empty instead.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/result_collector.sv
// Terminal stage of the neuron chain: buffers each result for a valid/ready
// consumer and classifies every NEURON_AMOUNT results by running argmax.
module result_collector
  import nn_pkg::*;
#(
  parameter  int unsigned RESULT_WIDTH  = RESULT_WIDTH_DEFAULT,
  parameter  int unsigned NEURON_AMOUNT = 4,
  parameter  int unsigned FIFO_DEPTH    = 8,
  localparam int unsigned INDEX_WIDTH   = $clog2(NEURON_AMOUNT)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic [RESULT_WIDTH:0]         input_result,
  output logic [RESULT_WIDTH-1:0]       output_data,
  output logic                          output_valid,
  input  logic                          output_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [INDEX_WIDTH-1:0]        class_index,
  output logic [RESULT_WIDTH-1:0]       class_value,
  output logic                          class_valid,
  output logic                          overflow
);

  localparam int unsigned VALID_BIT = result_valid_bit(RESULT_WIDTH);

  logic                    in_valid;
  logic [RESULT_WIDTH-1:0] in_value;
  logic                    accept;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    pop_fire;

  logic [INDEX_WIDTH-1:0]  pos_q;
  logic [RESULT_WIDTH-1:0] max_val_q;
  logic [INDEX_WIDTH-1:0]  max_idx_q;
  logic                    take_new;
  logic                    last_pos;
  logic [RESULT_WIDTH-1:0] win_val;
  logic [INDEX_WIDTH-1:0]  win_idx;

  // Decode the chain bus; a clear cycle swallows any arriving result.
  always_comb begin
    in_valid     = input_result[VALID_BIT];
    in_value     = input_result[RESULT_WIDTH-1:0];
    accept       = in_valid && !clear;
    output_valid = !fifo_empty;
    pop_fire     = output_valid && output_ready;
  end

  result_fifo #(
    .WIDTH (RESULT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .push    (accept),
    .pop     (output_ready),
    .wr_data (in_value),
    .rd_data (output_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Running-max candidate: position 0 always loads, later ones need strictly greater.
  always_comb begin
    take_new = (pos_q == '0) || (in_value > max_val_q);
    win_val  = take_new ? in_value : max_val_q;
    win_idx  = take_new ? pos_q    : max_idx_q;
    last_pos = (pos_q == INDEX_WIDTH'(NEURON_AMOUNT - 1));
  end

  // Frame position, running argmax and the classification pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q       <= '0;
      max_val_q   <= '0;
      max_idx_q   <= '0;
      class_index <= '0;
      class_value <= '0;
      class_valid <= 1'b0;
    end else if (clear) begin
      pos_q       <= '0;
      max_val_q   <= '0;
      max_idx_q   <= '0;
      class_valid <= 1'b0;
    end else begin
      class_valid <= 1'b0;
      if (accept) begin
        max_val_q <= win_val;
        max_idx_q <= win_idx;
        if (last_pos) begin
          pos_q       <= '0;
          class_index <= win_idx;
          class_value <= win_val;
          class_valid <= 1'b1;
        end else begin
          pos_q <= pos_q + 1'b1;
        end
      end
    end
  end

  // Sticky drop flag: a result that finds the FIFO full with no pop is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (clear) begin
      overflow <= 1'b0;
    end else if (accept && fifo_full && !pop_fire) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_result_collector.sv
// Self-checking bench for result_collector: queue-based reference model,
// per-cycle comparison, directed scenarios with literal expectations, random phase.
module tb_result_collector;

  localparam int unsigned RW = 16;
  localparam int unsigned NA = 4;
  localparam int unsigned FD = 8;
  localparam int unsigned IW = $clog2(NA);

  logic                   clk;
  logic                   rst_n;
  logic                   clear;
  logic [RW:0]            input_result;
  logic [RW-1:0]          output_data;
  logic                   output_valid;
  logic                   output_ready;
  logic [$clog2(FD):0]    fifo_count;
  logic [IW-1:0]          class_index;
  logic [RW-1:0]          class_value;
  logic                   class_valid;
  logic                   overflow;

  result_collector #(
    .RESULT_WIDTH  (RW),
    .NEURON_AMOUNT (NA),
    .FIFO_DEPTH    (FD)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .input_result (input_result),
    .output_data  (output_data),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .fifo_count   (fifo_count),
    .class_index  (class_index),
    .class_value  (class_value),
    .class_valid  (class_valid),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, frame as position + best-so-far.
  logic [RW-1:0] mq[$];
  int unsigned   m_pos, m_max, m_idx, m_ci, m_cv;
  bit            m_cvalid, m_ovf, m_pop, m_full;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        m_pos = 0; m_max = 0; m_idx = 0; m_ci = 0; m_cv = 0;
        m_cvalid = 0; m_ovf = 0;
      end else if (clear) begin
        mq.delete();
        m_pos = 0; m_max = 0; m_idx = 0;
        m_cvalid = 0; m_ovf = 0;
      end else begin
        m_cvalid = 0;
        m_full = (mq.size() == FD);
        m_pop  = (mq.size() > 0) && output_ready;
        if (m_pop) void'(mq.pop_front());
        if (input_result[RW]) begin
          if (!m_full || m_pop) mq.push_back(input_result[RW-1:0]);
          else m_ovf = 1;
          if (m_pos == 0 || int'(input_result[RW-1:0]) > m_max) begin
            m_max = input_result[RW-1:0];
            m_idx = m_pos;
          end
          if (m_pos == NA - 1) begin
            m_ci = m_idx; m_cv = m_max; m_cvalid = 1; m_pos = 0;
          end else begin
            m_pos++;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("output_valid", output_valid, (mq.size() > 0) ? 1 : 0);
        check("fifo_count", fifo_count, mq.size());
        if (mq.size() > 0) check("output_data", output_data, mq[0]);
        check("class_valid", class_valid, m_cvalid);
        check("class_index", class_index, m_ci);
        check("class_value", class_value, m_cv);
        check("overflow", overflow, m_ovf);
      end
    end
  end

  logic [RW-1:0] got[$];

  task automatic send(input int unsigned v);
    input_result = {1'b1, RW'(v)};
    @(negedge clk);
    input_result = '0;
  endtask

  task automatic idle(input int unsigned n);
    input_result = '0;
    for (int i = 0; i < int'(n); i++) @(negedge clk);
  endtask

  task automatic drain();
    got.delete();
    output_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (!output_valid) break;
      got.push_back(output_data);
      @(negedge clk);
    end
    output_ready = 1'b0;
  endtask

  task automatic check_list(input string name, input int unsigned exp[]);
    check({name, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      check(name, (i < got.size()) ? int'(got[i]) : 32'hDEAD_BEEF, exp[i]);
  endtask

  int unsigned pulses;
  int unsigned pulse_vals[2];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; input_result = '0; output_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_output_valid", output_valid, 0);
    check("rst_output_data", output_data, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_class_value", class_value, 0);
    check("rst_overflow", overflow, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Argmax tie keeps the lower position; FIFO order preserved.
    send(5); send(9); send(9); send(2);
    check("t1_class_valid", class_valid, 1);
    check("t1_class_index", class_index, 1);
    check("t1_class_value", class_value, 9);
    drain();
    check_list("t1_drain", '{5, 9, 9, 2});

    // Idle gaps do not move frame positions.
    send(3); send(0); idle(3); send(7); idle(1); send(1);
    check("t2_class_valid", class_valid, 1);
    check("t2_class_index", class_index, 2);
    check("t2_class_value", class_value, 7);
    drain();
    check_list("t2_drain", '{3, 0, 7, 1});

    // Overflow with consumer stalled; classification unaffected by drops.
    pulses = 0;
    for (int unsigned v = 1; v <= 10; v++) begin
      send(v);
      if (class_valid) begin
        if (pulses < 2) pulse_vals[pulses] = class_value;
        pulses++;
      end
      if (v == 8) check("t3_no_ovf_yet", overflow, 0);
      if (v == 9) check("t3_ovf_on_9", overflow, 1);
    end
    check("t3_pulses", pulses, 2);
    check("t3_pulse0", pulse_vals[0], 4);
    check("t3_pulse1", pulse_vals[1], 8);
    check("t3_count", fifo_count, 8);
    drain();
    check_list("t3_drain", '{1, 2, 3, 4, 5, 6, 7, 8});
    check("t3_ovf_sticky", overflow, 1);

    // Full FIFO with simultaneous push and pop.
    clear = 1'b1; @(negedge clk); clear = 1'b0;
    check("t4_ovf_cleared", overflow, 0);
    for (int unsigned v = 20; v < 28; v++) send(v);
    check("t4_full", fifo_count, 8);
    output_ready = 1'b1;
    send(16'hABCD);
    check("t4_count_kept", fifo_count, 8);
    check("t4_no_ovf", overflow, 0);
    drain();
    check_list("t4_drain", '{21, 22, 23, 24, 25, 26, 27, 16'hABCD});

    // Clear mid-frame discards the arriving result and the partial frame.
    clear = 1'b1; @(negedge clk); clear = 1'b0;
    send(10); send(11);
    clear = 1'b1; input_result = {1'b1, 16'hFFFF};
    @(negedge clk);
    clear = 1'b0; input_result = '0;
    check("t5_empty", fifo_count, 0);
    check("t5_ovf", overflow, 0);
    check("t5_no_pulse", class_valid, 0);
    check("t5_class_held", class_value, 27);
    send(1); send(2); send(3); send(4);
    check("t5_class_valid", class_valid, 1);
    check("t5_class_index", class_index, 3);
    check("t5_class_value", class_value, 4);
    drain();

    // Asynchronous reset mid-frame with entries buffered.
    send(7); send(8); send(9);
    check("t6_count3", fifo_count, 3);
    #3 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", output_valid, 0);
    check("t6_rst_data", output_data, 0);
    check("t6_rst_count", fifo_count, 0);
    check("t6_rst_cidx", class_index, 0);
    check("t6_rst_cval", class_value, 0);
    check("t6_rst_cvalid", class_valid, 0);
    check("t6_rst_ovf", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(6); send(6); send(6); send(6);
    check("t6_class_valid", class_valid, 1);
    check("t6_class_index", class_index, 0);
    check("t6_class_value", class_value, 6);
    drain();

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      clear        = ($urandom_range(0, 99) < 3);
      output_ready = ($urandom_range(0, 99) < 40);
      if ($urandom_range(0, 99) < 65)
        input_result = {1'b1, ($urandom_range(0, 1) == 1) ? RW'($urandom_range(0, 3)) : RW'($urandom)};
      else
        input_result = '0;
      @(negedge clk);
    end
    clear = 1'b0; input_result = '0; output_ready = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
